// File: rtl/axis_uart_pkg.sv
// Shared types and constants for the AXI-Stream UART transmit path.
// Holds the arbiter state encoding, the default beat width and a width helper.
package axis_uart_pkg;

    localparam int unsigned AXIS_DATA_BITS = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Index width for n items; never below 1 so single-bit selects stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// Bundle of the per-source AXI-Stream slave lanes, the single master lane
// toward the UART transmitter, and the arbiter status signals.
interface axis_uart_tx_arbiter_if
    import axis_uart_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned DATA_BITS = AXIS_DATA_BITS
);
    localparam int unsigned GW = clog2(NUM_SRC);

    logic [NUM_SRC*DATA_BITS-1:0] s_axis_data;
    logic [NUM_SRC-1:0]           s_axis_valid;
    logic [NUM_SRC-1:0]           s_axis_last;
    logic [NUM_SRC-1:0]           s_axis_ready;

    logic [DATA_BITS-1:0]         m_axis_data;
    logic                         m_axis_valid;
    logic                         m_axis_last;
    logic                         m_axis_ready;

    logic [GW-1:0]                grant_id;
    logic                         busy;

    // Arbiter side: owns the merged output stream and the per-source ready.
    modport master (
        input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
        output s_axis_ready, m_axis_data, m_axis_valid, m_axis_last,
        grant_id, busy
    );

    // Environment side: the requesters plus the transmitter's ready.
    modport slave (
        output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
        input  s_axis_ready, m_axis_data, m_axis_valid, m_axis_last,
        grant_id, busy
    );

endinterface

// File: rtl/axis_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick
    import axis_uart_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 2,
    localparam int unsigned GW      = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      winner,
    output logic               any
);

    logic [GW-1:0] idx;

    // Walk last_grant+1 .. last_grant+NUM_SRC; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = GW'((32'(last_grant) + k) % NUM_SRC);
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto the
// UART transmitter input; a grant is held from the first beat through last.
module axis_uart_tx_arbiter
    import axis_uart_pkg::*;
#(
    parameter  int unsigned NUM_SRC   = 2,
    parameter  int unsigned DATA_BITS = AXIS_DATA_BITS,
    localparam int unsigned GW        = clog2(NUM_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_uart_tx_arbiter_if.master bus
);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        grant_next;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_q;
    logic                 valid_next;
    logic                 last_q;
    logic                 last_next;
    logic                 busy_q;
    logic                 busy_next;

    logic [DATA_BITS-1:0] lane_data [NUM_SRC];
    logic [DATA_BITS-1:0] lane_data_c;
    logic                 lane_valid_c;
    logic                 lane_last_c;
    logic                 out_free_c;
    logic                 src_hs_c;
    logic [NUM_SRC-1:0]   ready_c;
    logic [GW-1:0]        winner;
    logic                 any_req;

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_pick (
        .req        (bus.s_axis_valid),
        .last_grant (grant_q),
        .winner     (winner),
        .any        (any_req)
    );

    // Split the flat source data bus into per-lane words.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        assign lane_data[g] = bus.s_axis_data[g*DATA_BITS +: DATA_BITS];
    end

    assign lane_data_c  = lane_data[grant_q];
    assign lane_valid_c = bus.s_axis_valid[grant_q];
    assign lane_last_c  = bus.s_axis_last[grant_q];

    // Output slot can take a beat when empty or draining this cycle.
    assign out_free_c = !valid_q || bus.m_axis_ready;
    assign src_hs_c   = (state == XFER) && out_free_c && lane_valid_c;

    always_comb begin
        ready_c = '0;
        if (state == XFER) begin
            ready_c[grant_q] = out_free_c;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant_q;
        data_next  = data_q;
        last_next  = last_q;
        valid_next = valid_q;

        if (src_hs_c) begin
            valid_next = 1'b1;
            data_next  = lane_data_c;
            last_next  = lane_last_c;
        end else if (valid_q && bus.m_axis_ready) begin
            valid_next = 1'b0;
        end

        // Requests are only looked at in IDLE; a grant lasts until last is taken.
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = XFER;
                    grant_next = winner;
                end
            end
            XFER: begin
                if (src_hs_c && lane_last_c) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == XFER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= GW'(NUM_SRC - 1);
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            data_q  <= data_next;
            valid_q <= valid_next;
            last_q  <= last_next;
            busy_q  <= busy_next;
        end
    end

    assign bus.s_axis_ready = ready_c;
    assign bus.m_axis_data  = data_q;
    assign bus.m_axis_valid = valid_q;
    assign bus.m_axis_last  = last_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: a 2-source instance checked every cycle
// against a packet-level model, plus a 4-source instance for fairness.
`timescale 1ns/1ps
module tb_axis_uart_tx_arbiter;
    import axis_uart_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_uart_tx_arbiter_if #(.NUM_SRC(2), .DATA_BITS(8)) bus2 ();
    axis_uart_tx_arbiter_if #(.NUM_SRC(4), .DATA_BITS(8)) bus4 ();

    axis_uart_tx_arbiter #(.NUM_SRC(2), .DATA_BITS(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    axis_uart_tx_arbiter #(.NUM_SRC(4), .DATA_BITS(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t      srcq [2][$];
    logic [7:0] out2_d [$];
    logic       out2_l [$];
    int         hs2_cyc [$];
    int         hs2_g [$];
    logic [7:0] out4_d [$];
    int         hs4_g [$];

    // Model state: granted source (-1 when idle), last grant, output slot.
    int         mg_gnt  = -1;
    int         mg_last = 1;
    logic       mo_v    = 1'b0;
    logic       mo_l    = 1'b0;
    logic [7:0] mo_d    = 8'h00;

    logic       p_v = 1'b0, p_r = 1'b0, p_l = 1'b0, p_rst = 1'b1;
    logic [7:0] p_d = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // One accepted beat per edge at most; a packet ends on its last beat.
    task automatic model_step();
        logic       was_idle, acc, found;
        logic [0:0] gi;
        logic [7:0] lane;
        int         c;
        was_idle = (mg_gnt < 0);
        gi       = was_idle ? 1'b0 : 1'(mg_gnt);
        lane     = gi ? bus2.s_axis_data[15:8] : bus2.s_axis_data[7:0];
        acc      = !was_idle && (!mo_v || bus2.m_axis_ready) && bus2.s_axis_valid[gi];
        if (acc) begin
            mo_v = 1'b1;
            mo_d = lane;
            mo_l = bus2.s_axis_last[gi];
            if (bus2.s_axis_last[gi]) mg_gnt = -1;
        end else if (mo_v && bus2.m_axis_ready) begin
            mo_v = 1'b0;
        end
        if (was_idle) begin
            found = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                c = (mg_last + k) % 2;
                if (!found && bus2.s_axis_valid[1'(c)]) begin
                    found   = 1'b1;
                    mg_gnt  = c;
                    mg_last = c;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mg_gnt = -1; mg_last = 1; mo_v = 1'b0; mo_l = 1'b0; mo_d = 8'h00;
        end else begin
            model_step();
        end
    end

    task automatic compare_cycle();
        logic [1:0] er;
        er = 2'b00;
        if (mg_gnt >= 0 && (!mo_v || bus2.m_axis_ready)) er[1'(mg_gnt)] = 1'b1;
        check("m_valid", bus2.m_axis_valid, mo_v);
        check("m_data", bus2.m_axis_data, mo_d);
        check("m_last", bus2.m_axis_last, mo_l);
        check("s_ready", bus2.s_axis_ready, er);
        check("grant_id", bus2.grant_id, mg_last);
        check("busy", bus2.busy, (mg_gnt >= 0) ? 1 : 0);
        check("ready_onehot2", $onehot0(bus2.s_axis_ready) ? 1 : 0, 1);
        check("ready_onehot4", $onehot0(bus4.s_axis_ready) ? 1 : 0, 1);
        if (p_v && !p_r && !p_rst && !rst) begin
            check("hold_valid", bus2.m_axis_valid, 1);
            check("hold_data", bus2.m_axis_data, p_d);
            check("hold_last", bus2.m_axis_last, p_l);
        end
    endtask

    // Compare and log on the falling edge, when everything has settled.
    initial forever begin
        @(negedge clk);
        compare_cycle();
        if (!rst) begin
            if (bus2.m_axis_valid && bus2.m_axis_ready) begin
                out2_d.push_back(bus2.m_axis_data);
                out2_l.push_back(bus2.m_axis_last);
            end
            if ((bus2.s_axis_ready & bus2.s_axis_valid) != 2'b00) begin
                hs2_cyc.push_back(cyc);
                hs2_g.push_back(int'(bus2.grant_id));
            end
            if (bus4.m_axis_valid && bus4.m_axis_ready) out4_d.push_back(bus4.m_axis_data);
            if ((bus4.s_axis_ready & bus4.s_axis_valid) != 4'b0000) hs4_g.push_back(int'(bus4.grant_id));
        end
        p_v = bus2.m_axis_valid; p_r = bus2.m_axis_ready; p_d = bus2.m_axis_data;
        p_l = bus2.m_axis_last;  p_rst = rst;
        cyc++;
    end

    // Source driver for the 2-source instance: pops on handshake, honours gaps.
    initial begin : drv2
        logic [1:0]  hs, nv, nl;
        logic [15:0] nd;
        beat_t       b;
        bus2.s_axis_valid = '0;
        bus2.s_axis_last  = '0;
        bus2.s_axis_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus2.s_axis_ready & bus2.s_axis_valid;
            @(posedge clk);
            #2;
            nv = '0; nl = '0; nd = '0;
            for (int i = 0; i < 2; i++) begin
                if (!rst && hs[1'(i)] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    if (b.gap > 0) begin
                        b.gap = b.gap - 1;
                        srcq[i][0] = b;
                    end else begin
                        nv[1'(i)]         = 1'b1;
                        nl[1'(i)]         = b.l;
                        nd[4'(8*i) +: 8] = b.d;
                    end
                end
            end
            bus2.s_axis_valid = nv;
            bus2.s_axis_last  = nl;
            bus2.s_axis_data  = nd;
        end
    end

    task automatic push(input int s, input logic [7:0] d, input logic l, input int gap);
        beat_t b;
        b.d = d; b.l = l; b.gap = gap;
        srcq[s].push_back(b);
    endtask

    task automatic clear_logs();
        out2_d.delete(); out2_l.delete(); hs2_cyc.delete(); hs2_g.delete();
    endtask

    task automatic wait_out2(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (out2_d.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(name, out2_d.size(), n);
    endtask

    task automatic check_seq(input string name, input logic [7:0] exp [$]);
        for (int k = 0; k < exp.size(); k++) begin
            if (k < out2_d.size()) check(name, out2_d[k], exp[k]);
            else check(name, -1, exp[k]);
        end
    endtask

    initial begin
        int cnt [4];
        int b;
        logic [7:0] e1 [$];
        logic [7:0] e2 [$];
        logic [7:0] e3 [$];
        logic [7:0] e4 [$];
        logic [7:0] e5 [$];
        bus2.m_axis_ready = 1'b0;
        bus4.m_axis_ready = 1'b0;
        bus4.s_axis_valid = '0;
        bus4.s_axis_last  = '0;
        bus4.s_axis_data  = '0;

        tick(3);
        check("rst_m_valid", bus2.m_axis_valid, 0);
        check("rst_m_data", bus2.m_axis_data, 0);
        check("rst_m_last", bus2.m_axis_last, 0);
        check("rst_busy", bus2.busy, 0);
        check("rst_s_ready", bus2.s_axis_ready, 0);
        check("rst_grant2", bus2.grant_id, 1);
        check("rst_grant4", bus4.grant_id, 3);
        rst = 1'b0;
        tick(2);

        // Two competing 3-beat packets: whole packets, src0 first.
        bus2.m_axis_ready = 1'b1;
        clear_logs();
        push(0, 8'hA1, 1'b0, 0); push(0, 8'hA2, 1'b0, 0); push(0, 8'hA3, 1'b1, 0);
        push(1, 8'hB1, 1'b0, 0); push(1, 8'hB2, 1'b0, 0); push(1, 8'hB3, 1'b1, 0);
        wait_out2(6, 40, "t1_count");
        e1 = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
        check_seq("t1_data", e1);
        if (out2_l.size() >= 6) begin
            check("t1_last_a", out2_l[2], 1);
            check("t1_last_b", out2_l[5], 1);
            check("t1_mid_last", out2_l[3], 0);
        end
        check("t1_src_hs", hs2_g.size(), 6);
        if (hs2_g.size() >= 6) begin
            check("t1_grant_a", hs2_g[0], 0);
            check("t1_grant_b", hs2_g[3], 1);
            check("t1_gap", hs2_cyc[3] - hs2_cyc[2], 2);
        end
        tick(3);

        // Backpressure: ready toggling every cycle.
        clear_logs();
        push(0, 8'h11, 1'b0, 0); push(0, 8'h22, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            bus2.m_axis_ready = (i % 2 == 0);
            tick();
        end
        bus2.m_axis_ready = 1'b1;
        wait_out2(2, 20, "bp_count");
        tick(4);
        check("bp_no_dup", out2_d.size(), 2);
        e2 = '{8'h11, 8'h22};
        check_seq("bp_data", e2);
        check("bp_grant", bus2.grant_id, 0);

        // Granted source stalls mid-packet while the other requests.
        clear_logs();
        push(0, 8'h31, 1'b0, 0); push(0, 8'h32, 1'b0, 8); push(0, 8'h33, 1'b1, 0);
        b = 0;
        while (!bus2.busy && b < 10) begin
            tick();
            b++;
        end
        check("stall_busy_seen", bus2.busy, 1);
        check("stall_grant", bus2.grant_id, 0);
        push(1, 8'h41, 1'b1, 0);
        repeat (5) begin
            tick();
            check("stall_busy", bus2.busy, 1);
            check("stall_rdy1", bus2.s_axis_ready[1], 0);
        end
        wait_out2(4, 40, "stall_count");
        e3 = '{8'h31, 8'h32, 8'h33, 8'h41};
        check_seq("stall_data", e3);
        if (hs2_g.size() >= 4) check("stall_grant_b", hs2_g[3], 1);
        tick(3);

        // Reset in the middle of a packet.
        clear_logs();
        push(0, 8'h51, 1'b0, 0); push(0, 8'h52, 1'b0, 0); push(0, 8'h53, 1'b1, 0);
        b = 0;
        while (!(bus2.m_axis_valid && bus2.m_axis_data == 8'h52) && b < 20) begin
            tick();
            b++;
        end
        check("mr_beat2_seen", bus2.m_axis_data, 8'h52);
        rst = 1'b1;
        #1;
        check("mr_m_valid", bus2.m_axis_valid, 0);
        check("mr_busy", bus2.busy, 0);
        check("mr_s_ready", bus2.s_axis_ready, 0);
        check("mr_grant", bus2.grant_id, 1);
        check("mr_m_data", bus2.m_axis_data, 0);
        srcq[0].delete();
        srcq[1].delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        clear_logs();
        push(0, 8'h61, 1'b1, 0);
        push(1, 8'h71, 1'b1, 0);
        wait_out2(2, 20, "mr_count");
        e4 = '{8'h61, 8'h71};
        check_seq("mr_data", e4);
        tick(3);

        // Fairness on four always-valid single-beat sources.
        bus4.m_axis_ready = 1'b1;
        bus4.s_axis_last  = 4'hF;
        bus4.s_axis_data  = {8'h43, 8'h42, 8'h41, 8'h40};
        bus4.s_axis_valid = 4'hF;
        b = 0;
        while (hs4_g.size() < 40 && b < 200) begin
            tick();
            b++;
        end
        bus4.s_axis_valid = 4'h0;
        tick(5);
        check("fair_src_hs", hs4_g.size(), 40);
        check("fair_out", out4_d.size(), 40);
        e5 = '{8'h40, 8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < out4_d.size(); k++) begin
            check("fair_order", out4_d[k], e5[k % 4]);
            if (out4_d[k] >= 8'h40 && out4_d[k] <= 8'h43) cnt[out4_d[k] - 8'h40]++;
        end
        for (int k = 0; k < hs4_g.size(); k++) check("fair_grant", hs4_g[k], k % 4);
        for (int i = 0; i < 4; i++) check("fair_share", cnt[i], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
